// File: rtl/wrr_arbiter_if.sv
//==============================================================================
// Module      : wrr_arbiter_if
// Description : Request/grant bundle between N requesters, the downstream
//               acknowledge source and the weighted round-robin arbiter.
//               master : drives req/weight/ack, observes grant/grant_id/busy
//               slave  : the arbiter side
//               Signals:
//                 req      [N]     per-requester level request
//                 weight   [N*WW]  per-requester burst weight, i at [i*WW +: WW]
//                 ack      [1]     downstream accepted one transfer this cycle
//                 grant    [N]     registered one-hot grant
//                 grant_id [IW]    binary index of the grantee
//                 busy     [1]     any grant bit set
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface wrr_arbiter_if #(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic            ack;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            busy;

  modport master (
    output req, weight, ack,
    input  grant, grant_id, busy
  );

  modport slave (
    input  req, weight, ack,
    output grant, grant_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/wrr_arbiter.sv
//==============================================================================
// Module      : wrr_arbiter
// Description : Parametrised weighted round-robin arbiter. The winner holds a
//               registered one-hot grant for up to max(weight,1) acknowledged
//               transfers, then priority rotates past it. Grants switch
//               back-to-back with no idle cycle.
//               Optional macro ARB_GAP_EN: insert one idle cycle (grant=0,
//               busy=0) after every release, including sole-requester re-grant.
//               Ports:
//                 clk   - clock, rising edge
//                 rst_n - asynchronous active-low reset
//                 bus   - wrr_arbiter_if.slave (req, weight, ack in;
//                         grant, grant_id, busy out)
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module wrr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  wrr_arbiter_if.slave bus
);

  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt;
  logic [N-1:0]  r_mask, w_mask_nxt;
  logic [IW-1:0] r_grant_id, w_grant_id_nxt;
  logic [WW-1:0] r_credit, w_credit_nxt;

  logic [N-1:0]  w_above;
  logic [N-1:0]  w_sel_mask;
  logic [N-1:0]  w_masked;
  logic [IW-1:0] w_win_id;
  logic [WW-1:0] w_win_wt;
  logic [WW-1:0] w_win_credit;
  logic [N-1:0]  w_win_onehot;
  logic          w_any_req;
  logic          w_release;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [IW-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  // Bits strictly above the current one-hot grantee: grant|(grant-1) covers
  // the grantee and everything below it.
  assign w_above = ~(r_grant | (r_grant - {{(N-1){1'b0}}, 1'b1}));

  always_comb begin
    w_release  = 1'b0;
    w_sel_mask = r_mask;
    if (r_state == S_GRANT) begin
      w_release = !bus.req[r_grant_id] || (bus.ack && (r_credit == {{(WW-1){1'b0}}, 1'b1}));
      // On release, selection already sees the rotated mask so the next
      // winner can be granted on the same edge.
      if (w_release) w_sel_mask = w_above;
    end

    w_any_req    = |bus.req;
    w_masked     = bus.req & w_sel_mask;
    // Wrap-around: nothing above the pointer means the lowest requester wins;
    // this also lets a sole requester re-win its own slot.
    w_win_id     = (|w_masked) ? lowest_idx(w_masked) : lowest_idx(bus.req);
    w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win_id;
    w_win_wt     = bus.weight[int'(w_win_id) * WW +: WW];
    w_win_credit = (w_win_wt == '0) ? {{(WW-1){1'b0}}, 1'b1} : w_win_wt;

    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_credit_nxt   = r_credit;
    w_mask_nxt     = r_mask;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = S_GRANT;
          w_grant_nxt    = w_win_onehot;
          w_grant_id_nxt = w_win_id;
          w_credit_nxt   = w_win_credit;
        end
      end

      S_GRANT: begin
        if (w_release) begin
          w_mask_nxt     = w_above;
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
          w_credit_nxt   = '0;
`ifdef ARB_GAP_EN
          // Stay idle for one cycle; IDLE picks the winner with the new mask.
`else
          if (w_any_req) begin
            w_state_nxt    = S_GRANT;
            w_grant_nxt    = w_win_onehot;
            w_grant_id_nxt = w_win_id;
            w_credit_nxt   = w_win_credit;
          end
`endif
        end else if (bus.ack) begin
          // credit > 1 here, since ack at credit 1 is a release.
          w_credit_nxt = r_credit - {{(WW-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
        w_credit_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_credit   <= '0;
      r_mask     <= '1;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_credit   <= w_credit_nxt;
      r_mask     <= w_mask_nxt;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = (r_state == S_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
//==============================================================================
// Module      : tb_wrr_arbiter
// Description : Directed self-checking bench for wrr_arbiter (N=4, WW=4).
//               Each step drives req/ack, pushes the expected grant for the
//               following edge into a queue, and compares after the edge.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wrr_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  wrr_arbiter_if #(.N(4), .WW(4)) bus ();

  wrr_arbiter #(.N(4), .WW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check_out(input string tag);
    logic [3:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (bus.grant === e) else begin
      errors++;
      $error("FAIL %s grant: observed %b expected %b", tag, bus.grant, e);
    end
    checks++;
    assert (bus.busy === (|e)) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", tag, bus.busy, |e);
    end
    if (|e) begin
      checks++;
      assert (bus.grant_id === idx_of(e)) else begin
        errors++;
        $error("FAIL %s grant_id: observed %0d expected %0d", tag, bus.grant_id, idx_of(e));
      end
    end
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic a, input logic [3:0] eg);
    @(negedge clk);
    bus.req = r;
    bus.ack = a;
    exp_q.push_back(eg);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic check_reset_id(input string tag);
    checks++;
    assert (bus.grant_id === 2'd0) else begin
      errors++;
      $error("FAIL %s grant_id: observed %0d expected 0", tag, bus.grant_id);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    exp_q.push_back(4'b0000);
    @(posedge clk);
    #1;
    check_out("reset");
    check_reset_id("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    bus.req    = 4'b0000;
    bus.ack    = 1'b0;
    bus.weight = 16'h1111;

    // Two requesters, weight 1: alternate every cycle with no bubble.
    do_reset();
    step("alt_c1", 4'b0101, 1'b0, 4'b0001);
    step("alt_c2", 4'b0101, 1'b1, 4'b0100);
    step("alt_c3", 4'b0101, 1'b1, 4'b0001);
    step("alt_c4", 4'b0101, 1'b1, 4'b0100);
    step("alt_c5", 4'b0101, 1'b1, 4'b0001);

    // All four requesting, weights {4,3,2,1}.
    do_reset();
    bus.weight = 16'h4321;
    step("wrr_c1",  4'b1111, 1'b0, 4'b0001);
    step("wrr_c2",  4'b1111, 1'b1, 4'b0010);
    step("wrr_c3",  4'b1111, 1'b1, 4'b0010);
    step("wrr_c4",  4'b1111, 1'b1, 4'b0100);
    step("wrr_c5",  4'b1111, 1'b1, 4'b0100);
    step("wrr_c6",  4'b1111, 1'b1, 4'b0100);
    step("wrr_c7",  4'b1111, 1'b1, 4'b1000);
    step("wrr_c8",  4'b1111, 1'b1, 4'b1000);
    step("wrr_c9",  4'b1111, 1'b1, 4'b1000);
    step("wrr_c10", 4'b1111, 1'b1, 4'b1000);
    step("wrr_c11", 4'b1111, 1'b1, 4'b0001);
    step("wrr_c12", 4'b1111, 1'b1, 4'b0010);

    // Sole requester 1 with weight 3, ack on alternate cycles; the re-grant
    // reload is then proven by needing three more acks before req0 wins.
    do_reset();
    bus.weight = 16'h0030;
    step("sole_c1", 4'b0010, 1'b0, 4'b0010);
    step("sole_c2", 4'b0010, 1'b1, 4'b0010);
    step("sole_c3", 4'b0010, 1'b0, 4'b0010);
    step("sole_c4", 4'b0010, 1'b1, 4'b0010);
    step("sole_c5", 4'b0010, 1'b0, 4'b0010);
    step("sole_c6", 4'b0010, 1'b1, 4'b0010);
    step("sole_c7", 4'b0011, 1'b1, 4'b0010);
    step("sole_c8", 4'b0011, 1'b1, 4'b0010);
    step("sole_c9", 4'b0011, 1'b1, 4'b0001);

    // Grantee 2 (weight 5) withdraws after 2 acks; req0 takes over, then
    // req3 beats req0 on the following rotation.
    do_reset();
    bus.weight = 16'h0500;
    step("wd_c1", 4'b0100, 1'b0, 4'b0100);
    step("wd_c2", 4'b0101, 1'b1, 4'b0100);
    step("wd_c3", 4'b0101, 1'b1, 4'b0100);
    step("wd_c4", 4'b0001, 1'b0, 4'b0001);
    step("wd_c5", 4'b1001, 1'b0, 4'b0001);
    step("wd_c6", 4'b1001, 1'b1, 4'b1000);

    // Weight 0 behaves as weight 1.
    do_reset();
    bus.weight = 16'h0000;
    step("w0_c1", 4'b0001, 1'b0, 4'b0001);
    step("w0_c2", 4'b0001, 1'b1, 4'b0001);
    step("w0_c3", 4'b0001, 1'b1, 4'b0001);
    step("w0_c4", 4'b0011, 1'b1, 4'b0010);
    step("w0_c5", 4'b0011, 1'b1, 4'b0001);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    bus.weight = 16'h0500;
    step("ar_c1", 4'b0100, 1'b0, 4'b0100);
    step("ar_c2", 4'b0100, 1'b1, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(4'b0000);
    check_out("async_reset");
    check_reset_id("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("ar_c3", 4'b1100, 1'b0, 4'b0100);
    step("ar_c4", 4'b1100, 1'b1, 4'b0100);

    checks++;
    assert (exp_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
